global_buffer_responder: RTL and testbench
==========================================

Name: global_buffer_responder

Overview:
- Buffer-side endpoint of the global buffer data interface: owns the on-chip word memory, executes global buffer instructions, accepts streamed writes and streams reads back.
- Sits between the host/DMA driver and the row-stationary array.
- Write handshake: the driver raises wr_en and holds it until ready is seen at a clock edge.

Parameters:
- dataSize, 8, bits per element.
- interfaceDepth, 16, elements per interface word; interfaceWidth = interfaceDepth*dataSize (128).
- bufferDepth, 64, number of interfaceWidth words in memory; power of two; PW = $clog2(bufferDepth).
- addrWidth, 32, width of start-address and length inputs; only the low PW bits are used.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- instr_i  input  4  global_buffer_instruction_t opcode.
- instr_valid_i  input  1  opcode valid.
- instr_ready_o  output  1  opcode accepted this edge when instr_valid_i=1.
- weight_start_addr_i  input  addrWidth  word address of the weight region.
- activation_start_addr_i  input  addrWidth  word address of the activation region.
- output_start_addr_i  input  addrWidth  word address of the output region.
- rd_len_i  input  addrWidth  word count for I_READ_ACTIVATION, sampled at accept.
- wr_data_i  input  interfaceWidth  write word.
- wr_en_i  input  1  write request.
- ready_o  output  1  write accepted on an edge where wr_en_i=1.
- rd_data_o  output  interfaceWidth  read word.
- rd_data_valid_o  output  1  rd_data_o valid.
- full_o  output  1  write pointer ran past the last word.

Behaviour:
- States: IDLE, LOAD, READ.
- Reset (async, any state): state=IDLE, wr_ptr=0, rd_ptr=0, rd_cnt=0, full=0.
- Output reset values: rd_data_o=0, rd_data_valid_o=0, ready_o=0, full_o=0, instr_ready_o=1.
- instr_ready_o = (state != READ). Opcodes presented during READ are ignored; they are not queued.
- I_NOP: no effect. State is unchanged, including while in LOAD.
- I_POINTER_RESET: wr_ptr=0, rd_ptr=0, full=0, state=IDLE.
- I_LOAD_WEIGHT: wr_ptr = weight_start_addr_i[PW-1:0], full=0, state=LOAD.
- I_LOAD_ACTIVATION: same as I_LOAD_WEIGHT using activation_start_addr_i.
- I_LOAD_OUTPUT: same as I_LOAD_WEIGHT using output_start_addr_i.
- I_READ_ACTIVATION:
  - rd_len_i=0: no-op, stay IDLE (or leave LOAD for IDLE).
  - Otherwise: rd_ptr = activation start, rd_cnt = rd_len_i, state=READ.
- Undefined opcodes (6..15): treated as I_NOP.
- Writes:
  - ready_o = (state==LOAD) && !full, combinational from registered state.
  - On an edge with wr_en_i && ready_o: mem[wr_ptr] <= wr_data_i.
  - If wr_ptr == bufferDepth-1, set full=1 and hold wr_ptr; otherwise wr_ptr+1.
  - Writes are never wrapped. wr_en_i with ready_o=0 is dropped silently.
- Write and opcode on the same edge in LOAD: the write commits at the old wr_ptr; the opcode then reloads the pointer and state.
- Reads:
  - Synchronous memory, 1-cycle latency. At each edge in READ: rd_data_o <= mem[rd_ptr], rd_data_valid_o <= 1, rd_ptr wraps modulo bufferDepth, rd_cnt decrements.
  - When rd_cnt reaches 0 after a read: state=IDLE. rd_data_valid_o drops at the following edge.
  - Sequence: opcode accepted at edge E0. Valid is high after edges E1..EL (L = rd_len) for exactly L consecutive cycles, with no gaps.
  - There is no backpressure on reads.
  - rd_data_o holds its last value when not valid.
- Read at an address written on the same edge: old data is returned (read-before-write). This case cannot occur under the state rules but must not corrupt memory.
- full_o = full. It is cleared by any LOAD opcode or by I_POINTER_RESET.
- rst asserted mid-LOAD or mid-READ: outputs drop to their reset values immediately. Memory contents are not cleared.

Test Plan:
- Reset then idle: after rst, ready_o=0, rd_data_valid_o=0, instr_ready_o=1; wr_en_i=1 with data 0xAA.. in IDLE leaves the memory unchanged.
- Weight load and readback: weight_start=4, I_LOAD_WEIGHT, write words 0x11..,0x22..,0x33.. back-to-back; then activation_start=4, rd_len=3, I_READ_ACTIVATION → valid high for exactly 3 cycles starting 1 cycle after accept, data 0x11..,0x22..,0x33.., instr_ready_o=0 throughout.
- Full boundary: I_LOAD_OUTPUT with output_start=62, write 3 words → words land at 62 and 63, full_o=1 and ready_o=0 after the second write, the third word is dropped, word 0 is unchanged.
- Read wrap: activation_start=63, rd_len=2 → returns mem[63] then mem[0].
- Simultaneous edge: in LOAD at wr_ptr=10, wr_en_i together with I_LOAD_ACTIVATION (start=20) → word stored at 10; the next write stores at 20.
- Reset mid-read: rd_len=8, assert rst after 3 valid cycles → rd_data_valid_o=0 immediately, state IDLE; a fresh read then returns the previously written data intact.

Source files
------------

// File: rtl/global_buffer_responder.sv
// global_buffer_responder
// Buffer-side endpoint of the global buffer data interface. Owns the on-chip
// word memory, executes global buffer instructions, accepts streamed writes
// (driver holds wr_en_i until ready_o is seen at an edge) and streams reads
// back with a one-cycle synchronous memory latency.
//
// Ports:
//   clk, rst                  clock (rising edge), async active-high reset
//   instr_i/instr_valid_i     opcode and its valid
//   instr_ready_o             opcode accepted (low while streaming a read)
//   *_start_addr_i            word addresses of weight/activation/output regions
//   rd_len_i                  word count for I_READ_ACTIVATION
//   wr_data_i/wr_en_i/ready_o write word, request, acceptance
//   rd_data_o/rd_data_valid_o read word and its valid
//   full_o                    write pointer ran past the last word
module global_buffer_responder #(
  parameter  int dataSize       = 8,
  parameter  int interfaceDepth = 16,
  parameter  int bufferDepth    = 64,
  parameter  int addrWidth      = 32,
  localparam int interfaceWidth = interfaceDepth * dataSize,
  localparam int PW             = $clog2(bufferDepth)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [3:0]                instr_i,
  input  logic                      instr_valid_i,
  output logic                      instr_ready_o,
  input  logic [addrWidth-1:0]      weight_start_addr_i,
  input  logic [addrWidth-1:0]      activation_start_addr_i,
  input  logic [addrWidth-1:0]      output_start_addr_i,
  input  logic [addrWidth-1:0]      rd_len_i,
  input  logic [interfaceWidth-1:0] wr_data_i,
  input  logic                      wr_en_i,
  output logic                      ready_o,
  output logic [interfaceWidth-1:0] rd_data_o,
  output logic                      rd_data_valid_o,
  output logic                      full_o
);

  typedef enum logic [3:0] {
    I_NOP             = 4'd0,
    I_POINTER_RESET   = 4'd1,
    I_LOAD_WEIGHT     = 4'd2,
    I_LOAD_ACTIVATION = 4'd3,
    I_LOAD_OUTPUT     = 4'd4,
    I_READ_ACTIVATION = 4'd5
  } global_buffer_instruction_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    READ = 2'd2
  } state_t;

  localparam logic [PW-1:0]        LAST_ADDR = PW'(bufferDepth - 1);
  localparam logic [PW-1:0]        PTR_ONE   = PW'(1);
  localparam logic [PW-1:0]        PTR_ZERO  = PW'(0);
  localparam logic [addrWidth-1:0] CNT_ONE   = addrWidth'(1);
  localparam logic [addrWidth-1:0] CNT_ZERO  = addrWidth'(0);

  state_t                   state_r, state_n;
  logic [PW-1:0]            wr_ptr_r, wr_ptr_n;
  logic [PW-1:0]            rd_ptr_r, rd_ptr_n;
  logic [addrWidth-1:0]     rd_cnt_r, rd_cnt_n;
  logic                     full_r, full_n;
  logic [interfaceWidth-1:0] rd_data_r;
  logic                     rd_valid_r;
  logic                     wr_fire_s;
  logic [interfaceWidth-1:0] mem_r [bufferDepth];

  // Only the low PW address bits select a word; the rest are intentionally ignored.
  logic unused_addr_s;
  assign unused_addr_s = ^{weight_start_addr_i[addrWidth-1:PW],
                           activation_start_addr_i[addrWidth-1:PW],
                           output_start_addr_i[addrWidth-1:PW]};

  assign ready_o         = (state_r == LOAD) && !full_r;
  assign instr_ready_o   = (state_r != READ);
  assign wr_fire_s       = wr_en_i && ready_o;
  assign full_o          = full_r;
  assign rd_data_o       = rd_data_r;
  assign rd_data_valid_o = rd_valid_r;

  // State and pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      rd_cnt_r <= CNT_ZERO;
      full_r   <= 1'b0;
    end else begin
      state_r  <= state_n;
      wr_ptr_r <= wr_ptr_n;
      rd_ptr_r <= rd_ptr_n;
      rd_cnt_r <= rd_cnt_n;
      full_r   <= full_n;
    end
  end

  // Next-state logic: the write updates pointers first, then an accepted
  // opcode overrides them, so a same-edge write lands at the old wr_ptr.
  always_comb begin
    state_n  = state_r;
    wr_ptr_n = wr_ptr_r;
    rd_ptr_n = rd_ptr_r;
    rd_cnt_n = rd_cnt_r;
    full_n   = full_r;

    if (wr_fire_s) begin
      // Writes never wrap: the last word sets full and parks the pointer.
      if (wr_ptr_r == LAST_ADDR) begin
        full_n = 1'b1;
      end else begin
        wr_ptr_n = wr_ptr_r + PTR_ONE;
      end
    end else begin
      wr_ptr_n = wr_ptr_r;
    end

    if (state_r == READ) begin
      // Opcodes are ignored while streaming; the read pointer wraps freely.
      rd_ptr_n = rd_ptr_r + PTR_ONE;
      rd_cnt_n = rd_cnt_r - CNT_ONE;
      if (rd_cnt_r == CNT_ONE) begin
        state_n = IDLE;
      end else begin
        state_n = READ;
      end
    end else if (instr_valid_i) begin
      case (instr_i)
        I_POINTER_RESET: begin
          wr_ptr_n = PTR_ZERO;
          rd_ptr_n = PTR_ZERO;
          full_n   = 1'b0;
          state_n  = IDLE;
        end
        I_LOAD_WEIGHT: begin
          wr_ptr_n = weight_start_addr_i[PW-1:0];
          full_n   = 1'b0;
          state_n  = LOAD;
        end
        I_LOAD_ACTIVATION: begin
          wr_ptr_n = activation_start_addr_i[PW-1:0];
          full_n   = 1'b0;
          state_n  = LOAD;
        end
        I_LOAD_OUTPUT: begin
          wr_ptr_n = output_start_addr_i[PW-1:0];
          full_n   = 1'b0;
          state_n  = LOAD;
        end
        I_READ_ACTIVATION: begin
          if (rd_len_i == CNT_ZERO) begin
            state_n = IDLE;
          end else begin
            rd_ptr_n = activation_start_addr_i[PW-1:0];
            rd_cnt_n = rd_len_i;
            state_n  = READ;
          end
        end
        default: begin
          state_n = state_r;
        end
      endcase
    end else begin
      state_n = state_r;
    end
  end

  // Word memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_fire_s) begin
      mem_r[wr_ptr_r] <= wr_data_i;
    end
  end

  // Synchronous read port: data holds its last value when no read is issued,
  // and a same-edge write to the same word returns the old contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_r  <= '0;
      rd_valid_r <= 1'b0;
    end else begin
      rd_valid_r <= (state_r == READ);
      if (state_r == READ) begin
        rd_data_r <= mem_r[rd_ptr_r];
      end
    end
  end

endmodule

// File: tb/tb_global_buffer_responder.sv
module tb_global_buffer_responder;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   instr_i = 4'd0;
  logic         instr_valid_i = 1'b0;
  logic         instr_ready_o;
  logic [31:0]  weight_start_addr_i = 32'd0;
  logic [31:0]  activation_start_addr_i = 32'd0;
  logic [31:0]  output_start_addr_i = 32'd0;
  logic [31:0]  rd_len_i = 32'd0;
  logic [127:0] wr_data_i = 128'd0;
  logic         wr_en_i = 1'b0;
  logic         ready_o;
  logic [127:0] rd_data_o;
  logic         rd_data_valid_o;
  logic         full_o;

  int checks = 0;
  int failures = 0;

  global_buffer_responder dut (
    .clk(clk), .rst(rst),
    .instr_i(instr_i), .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
    .weight_start_addr_i(weight_start_addr_i),
    .activation_start_addr_i(activation_start_addr_i),
    .output_start_addr_i(output_start_addr_i),
    .rd_len_i(rd_len_i),
    .wr_data_i(wr_data_i), .wr_en_i(wr_en_i), .ready_o(ready_o),
    .rd_data_o(rd_data_o), .rd_data_valid_o(rd_data_valid_o), .full_o(full_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  ins;
    logic        iv;
    logic        we;
    logic [7:0]  wb;
    logic [31:0] addr;
    logic [31:0] len;
    logic        e_ready;
    logic        e_ir;
    logic        e_valid;
    logic        cd;
    logic [7:0]  eb;
    logic        e_full;
  } vec_t;

  vec_t vq[$];
  int   mid_idx;

  function automatic logic [127:0] rep(input logic [7:0] b);
    return {16{b}};
  endfunction

  task automatic add(input logic [3:0] ins, input logic iv, input logic we,
                     input logic [7:0] wb, input logic [31:0] addr, input logic [31:0] len,
                     input logic er, input logic eir, input logic ev,
                     input logic cd, input logic [7:0] eb, input logic ef);
    vec_t v;
    v.ins = ins; v.iv = iv; v.we = we; v.wb = wb; v.addr = addr; v.len = len;
    v.e_ready = er; v.e_ir = eir; v.e_valid = ev; v.cd = cd; v.eb = eb; v.e_full = ef;
    vq.push_back(v);
  endtask

  task automatic chk1(input string nm, input int row, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d got=%b expected=%b", nm, row, act, exp);
    end
  endtask

  task automatic chkd(input string nm, input int row, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d got=%h expected=%h", nm, row, act, exp);
    end
  endtask

  task automatic idle_inputs();
    instr_i = 4'd0; instr_valid_i = 1'b0; wr_en_i = 1'b0; wr_data_i = 128'd0;
    rd_len_i = 32'd0;
  endtask

  task automatic apply(input int row, input vec_t v);
    @(negedge clk);
    instr_i = v.ins; instr_valid_i = v.iv; wr_en_i = v.we; wr_data_i = rep(v.wb);
    weight_start_addr_i = v.addr; activation_start_addr_i = v.addr;
    output_start_addr_i = v.addr; rd_len_i = v.len;
    @(posedge clk);
    #1;
    chk1("ready", row, ready_o, v.e_ready);
    chk1("instr_ready", row, instr_ready_o, v.e_ir);
    chk1("rd_valid", row, rd_data_valid_o, v.e_valid);
    chk1("full", row, full_o, v.e_full);
    if (v.cd) chkd("rd_data", row, rd_data_o, rep(v.eb));
  endtask

  initial begin
    // ins iv we wb addr len | ready ir valid cd eb full
    add(4'd2, 1, 0, 8'h00, 0,  0, 1, 1, 0, 0, 8'h00, 0); // load weight @0
    add(4'd0, 0, 1, 8'h55, 0,  0, 1, 1, 0, 0, 8'h00, 0); // word0 = 55
    add(4'd1, 1, 0, 8'h00, 0,  0, 0, 1, 0, 0, 8'h00, 0); // pointer reset
    add(4'd0, 0, 1, 8'hAA, 0,  0, 0, 1, 0, 0, 8'h00, 0); // idle write dropped
    add(4'd2, 1, 0, 8'h00, 4,  0, 1, 1, 0, 0, 8'h00, 0); // load weight @4
    add(4'd0, 1, 0, 8'h00, 0,  0, 1, 1, 0, 0, 8'h00, 0); // NOP keeps LOAD
    add(4'd9, 1, 0, 8'h00, 0,  0, 1, 1, 0, 0, 8'h00, 0); // undefined = NOP
    add(4'd0, 0, 1, 8'h11, 0,  0, 1, 1, 0, 0, 8'h00, 0);
    add(4'd0, 0, 1, 8'h22, 0,  0, 1, 1, 0, 0, 8'h00, 0);
    add(4'd0, 0, 1, 8'h33, 0,  0, 1, 1, 0, 0, 8'h00, 0);
    add(4'd5, 1, 0, 8'h00, 4,  3, 0, 0, 0, 0, 8'h00, 0); // read 4..6
    add(4'd0, 0, 0, 8'h00, 0,  0, 0, 0, 1, 1, 8'h11, 0);
    add(4'd2, 1, 0, 8'h00, 0,  0, 0, 0, 1, 1, 8'h22, 0); // opcode ignored in READ
    add(4'd0, 0, 0, 8'h00, 0,  0, 0, 1, 1, 1, 8'h33, 0);
    add(4'd0, 0, 0, 8'h00, 0,  0, 0, 1, 0, 1, 8'h33, 0); // valid drops, data holds
    add(4'd5, 1, 0, 8'h00, 0,  1, 0, 0, 0, 1, 8'h33, 0); // read word0
    add(4'd0, 0, 0, 8'h00, 0,  0, 0, 1, 1, 1, 8'h55, 0);
    add(4'd0, 0, 0, 8'h00, 0,  0, 0, 1, 0, 1, 8'h55, 0);
    add(4'd5, 1, 0, 8'h00, 0,  0, 0, 1, 0, 0, 8'h00, 0); // rd_len 0 no-op
    add(4'd0, 0, 0, 8'h00, 0,  0, 0, 1, 0, 0, 8'h00, 0);
    add(4'd4, 1, 0, 8'h00, 62, 0, 1, 1, 0, 0, 8'h00, 0); // load output @62
    add(4'd0, 0, 1, 8'h66, 0,  0, 1, 1, 0, 0, 8'h00, 0);
    add(4'd0, 0, 1, 8'h77, 0,  0, 0, 1, 0, 0, 8'h00, 1); // last word -> full
    add(4'd0, 0, 1, 8'h88, 0,  0, 0, 1, 0, 0, 8'h00, 1); // dropped
    add(4'd5, 1, 0, 8'h00, 62, 3, 0, 0, 0, 0, 8'h00, 1); // read 62,63,0 (wrap)
    add(4'd0, 0, 0, 8'h00, 0,  0, 0, 0, 1, 1, 8'h66, 1);
    add(4'd0, 0, 0, 8'h00, 0,  0, 0, 0, 1, 1, 8'h77, 1);
    add(4'd0, 0, 0, 8'h00, 0,  0, 0, 1, 1, 1, 8'h55, 1);
    add(4'd0, 0, 0, 8'h00, 0,  0, 0, 1, 0, 1, 8'h55, 1);
    add(4'd2, 1, 0, 8'h00, 10, 0, 1, 1, 0, 0, 8'h00, 0); // load @10 clears full
    add(4'd3, 1, 1, 8'h99, 20, 0, 1, 1, 0, 0, 8'h00, 0); // write@10 + reload @20
    add(4'd0, 0, 1, 8'hBB, 0,  0, 1, 1, 0, 0, 8'h00, 0); // lands @20
    add(4'd5, 1, 0, 8'h00, 0,  0, 0, 1, 0, 0, 8'h00, 0); // len0 leaves LOAD
    add(4'd5, 1, 0, 8'h00, 10, 1, 0, 0, 0, 0, 8'h00, 0);
    add(4'd0, 0, 0, 8'h00, 0,  0, 0, 1, 1, 1, 8'h99, 0);
    add(4'd5, 1, 0, 8'h00, 20, 1, 0, 0, 0, 0, 8'h00, 0);
    add(4'd0, 0, 0, 8'h00, 0,  0, 0, 1, 1, 1, 8'hBB, 0);
    add(4'd5, 1, 0, 8'h00, 4,  8, 0, 0, 0, 0, 8'h00, 0); // long read, reset mid-way
    add(4'd0, 0, 0, 8'h00, 0,  0, 0, 0, 1, 1, 8'h11, 0);
    add(4'd0, 0, 0, 8'h00, 0,  0, 0, 0, 1, 1, 8'h22, 0);
    add(4'd0, 0, 0, 8'h00, 0,  0, 0, 0, 1, 1, 8'h33, 0);
    mid_idx = vq.size();
    add(4'd5, 1, 0, 8'h00, 4,  3, 0, 0, 0, 1, 8'h00, 0); // fresh read after reset
    add(4'd0, 0, 0, 8'h00, 0,  0, 0, 0, 1, 1, 8'h11, 0);
    add(4'd0, 0, 0, 8'h00, 0,  0, 0, 0, 1, 1, 8'h22, 0);
    add(4'd0, 0, 0, 8'h00, 0,  0, 0, 1, 1, 1, 8'h33, 0);
    add(4'd0, 0, 0, 8'h00, 0,  0, 0, 1, 0, 1, 8'h33, 0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_ready", -1, ready_o, 1'b0);
    chk1("rst_instr_ready", -1, instr_ready_o, 1'b1);
    chk1("rst_valid", -1, rd_data_valid_o, 1'b0);
    chk1("rst_full", -1, full_o, 1'b0);
    chkd("rst_data", -1, rd_data_o, 128'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      if (i == mid_idx) begin
        // Asynchronous reset in the middle of the read stream
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        #1;
        chk1("midrst_valid", i, rd_data_valid_o, 1'b0);
        chk1("midrst_instr_ready", i, instr_ready_o, 1'b1);
        chk1("midrst_ready", i, ready_o, 1'b0);
        chkd("midrst_data", i, rd_data_o, 128'd0);
        @(negedge clk);
        rst = 1'b0;
      end
      apply(i, vq[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
